// File: rtl/aes_pkg.sv
// AES-128 shared definitions: S-box table, Rcon, FSM encoding and round-function helpers.
// Optional S-box output registering in the encryptor is enabled by AES_SBOX_PIPE_EN.
package aes_pkg;

  typedef enum logic [1:0] {StIdle, StRound, StFinal} aes_state_e;

  // Entry for input byte 0 occupies bits [2047:2040].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column-major layout: byte (row, col) is index row + 4*col, byte 0 at the MSB.
  function automatic int unsigned byte_lsb(input int unsigned row, input int unsigned col);
    return 8 * (15 - row - 4 * col);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned row = 0; row < 4; row++) begin
        r[byte_lsb(row, c) +: 8] = s[byte_lsb(row, (c + row) % 4) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      r[96 - 32 * c +: 32] = mix_column(s[96 - 32 * c +: 32]);
    end
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // sub_rot is SubWord(RotWord(w3)) of the current round key.
  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [31:0] sub_rot,
                                              input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot ^ {rcon, 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: combinational 8-bit table lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  assign data_o = SBOX[{~data_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_encryptor_top.sv
// Iterative AES-128 encryptor, one round per step with on-the-fly key expansion.
// Define AES_SBOX_PIPE_EN to register all S-box outputs (two edges per round).
module aes_encryptor_top
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         valid,
  output logic [127:0] ciphertext_out
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS - 1);

  aes_state_e   state_q, state_d;
  logic [127:0] data_q, rk_q, ct_q;
  logic [3:0]   rnd_q;
  logic         valid_q;
  logic [127:0] sb_data, sub_data;
  logic [31:0]  sb_key, sub_key, key_rot;
  logic         step;
  logic [127:0] rk_next, round_out, final_out;

  assign key_rot = rot_word(rk_q[31:0]);

  for (genvar i = 0; i < 16; i++) begin : g_data_sbox
    aes_sbox u_sbox (
      .data_i(data_q[127 - 8 * i -: 8]),
      .data_o(sb_data[127 - 8 * i -: 8])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (
      .data_i(key_rot[31 - 8 * i -: 8]),
      .data_o(sb_key[31 - 8 * i -: 8])
    );
  end

`ifdef AES_SBOX_PIPE_EN
  logic         phase_q;  // 0: SUB captures S-box outputs, 1: MIX commits the round
  logic [127:0] sub_data_q;
  logic [31:0]  sub_key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 1'b0;
      sub_data_q <= '0;
      sub_key_q  <= '0;
    end else begin
      phase_q    <= (state_q != StIdle) ? ~phase_q : 1'b0;
      sub_data_q <= sb_data;
      sub_key_q  <= sb_key;
    end
  end

  assign step     = phase_q;
  assign sub_data = sub_data_q;
  assign sub_key  = sub_key_q;
`else
  assign step     = 1'b1;
  assign sub_data = sb_data;
  assign sub_key  = sb_key;
`endif

  assign rk_next   = key_expand(rk_q, sub_key, RCON[rnd_q]);
  assign round_out = mix_columns(shift_rows(sub_data)) ^ rk_next;
  assign final_out = shift_rows(sub_data) ^ rk_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRound;
      StRound: if (step && rnd_q == LastRound) state_d = StFinal;
      StFinal: if (step) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      ct_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            data_q <= plaintext ^ key;
            rk_q   <= key;
            rnd_q  <= 4'd1;
          end
        end
        StRound: begin
          if (step) begin
            data_q <= round_out;
            rk_q   <= rk_next;
            rnd_q  <= rnd_q + 4'd1;
          end
        end
        StFinal: begin
          if (step) begin
            ct_q    <= final_out;
            valid_q <= 1'b1;
            rnd_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy           = (state_q != StIdle);
    valid          = valid_q;
    ciphertext_out = ct_q;
  end

endmodule

// File: tb/tb_aes_encryptor_top.sv
// Self-checking bench for aes_encryptor_top: FIPS-197 vectors, handshake corner cases,
// reset abort and random blocks against a byte-array AES model (AES_SBOX_PIPE_EN aware).
module tb_aes_encryptor_top;

`ifdef AES_SBOX_PIPE_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 10;
`endif

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ZC  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] plaintext = '0;
  logic         busy, valid;
  logic [127:0] ciphertext_out;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;
  logic [7:0] sbox_t [256];

  aes_encryptor_top #(
    .NUM_ROUNDS(10)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .key           (key),
    .plaintext     (plaintext),
    .busy          (busy),
    .valid         (valid),
    .ciphertext_out(ciphertext_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) n_valid++;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_t[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [7:0] w [176];
    logic [7:0] st [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, t0, a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) w[i] = k[127 - 8 * i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4 * (i - 1) + j];
      if (i % 4 == 0) begin
        t0 = tmp[0];
        tmp[0] = sbox_t[tmp[1]] ^ rc;
        tmp[1] = sbox_t[tmp[2]];
        tmp[2] = sbox_t[tmp[3]];
        tmp[3] = sbox_t[t0];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4 * i + j] = w[4 * (i - 4) + j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) st[i] = p[127 - 8 * i -: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[st[i]];
      for (int c = 0; c < 4; c++) begin
        for (int row = 0; row < 4; row++) st[row + 4 * c] = t[row + 4 * ((c + row) % 4)];
      end
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4 * c]; a1 = st[4 * c + 1]; a2 = st[4 * c + 2]; a3 = st[4 * c + 3];
          t[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        for (int i = 0; i < 16; i++) st[i] = t[i];
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[16 * r + i];
    end
    out = '0;
    for (int i = 0; i < 16; i++) out[127 - 8 * i -: 8] = st[i];
    return out;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Pulses start for one cycle from the current negedge; returns just after edge N.
  task automatic launch(input string tag, input logic [127:0] k, input logic [127:0] p);
    start = 1'b1;
    key = k;
    plaintext = p;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, ".busy0"}, 128'(busy), 128'd1);
  endtask

  // Waits (bounded) for valid; ghost = edge offset of an extra start to inject while busy.
  task automatic wait_done(input string tag, input logic [127:0] exp, input int ghost,
                           input bit noisy);
    int e;
    int bad;
    e = 0;
    bad = 0;
    while (!valid && e < 3 * LAT) begin
      start = ((e + 1 == ghost) || (noisy && $urandom_range(0, 2) == 0)) && (e + 1 < LAT);
      if (noisy) begin
        key = rand128();
        plaintext = rand128();
      end
      @(negedge clk);
      e++;
      if (valid ? busy : !busy) bad++;
    end
    start = 1'b0;
    check_eq({tag, ".lat"}, 128'(e), 128'(LAT));
    check_eq({tag, ".busy"}, 128'(bad), 128'd0);
    check_eq({tag, ".ct"}, ciphertext_out, exp);
  endtask

  initial begin
    int v0;
    logic [127:0] k, p;
    build_sbox();
    repeat (2) @(negedge clk);
    check_eq("rst.busy", 128'(busy), 128'd0);
    check_eq("rst.valid", 128'(valid), 128'd0);
    check_eq("rst.ct", ciphertext_out, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    launch("c1", C1K, C1P);
    wait_done("c1", C1C, 0, 1'b0);
    @(negedge clk);
    check_eq("c1.pulse", 128'(valid), 128'd0);

    launch("fipsb", BK, BP);
    key = '0;
    plaintext = '0;
    wait_done("fipsb", BC, 0, 1'b0);

    @(negedge clk);
    v0 = n_valid;
    launch("b2b1", C1K, C1P);
    wait_done("b2b1", C1C, 4, 1'b0);
    launch("b2b2", BK, BP);
    wait_done("b2b2", BC, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("b2b.pulses", 128'(n_valid - v0), 128'd2);

    launch("abort", C1K, C1P);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort.busy", 128'(busy), 128'd0);
    check_eq("abort.valid", 128'(valid), 128'd0);
    check_eq("abort.ct", ciphertext_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid;
    repeat (20) @(negedge clk);
    check_eq("abort.novalid", 128'(n_valid - v0), 128'd0);
    launch("rerun", C1K, C1P);
    wait_done("rerun", C1C, 0, 1'b0);

    @(negedge clk);
    launch("zero", 128'd0, 128'd0);
    wait_done("zero", ZC, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      k = rand128();
      p = rand128();
      @(negedge clk);
      launch($sformatf("rnd%0d", i), k, p);
      wait_done($sformatf("rnd%0d", i), aes_ref(k, p), 0, 1'b1);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_encryptor_top.md
Name: aes_encryptor_top

Overview:
Iterative AES-128 encryptor. It is the forward-direction counterpart of the team's AES-128 decryptor top and shares its start/valid handshake and 128-bit data conventions. The block computes one round per clock and expands the round key on the fly alongside the data path, so it needs no round-key memory. It sits at the same level in the design as the decryptor top, and the two are driven from the same block-level control.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; fixed to 10 for AES-128, any other value is unsupported.

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; key and plaintext are valid in this cycle
key  input  128  AES-128 cipher key; bits [127:120] are byte 0 (FIPS-197 order)
plaintext  input  128  block to encrypt; same byte order as key
busy  output  1  high while an encryption is in progress
valid  output  1  one-cycle pulse when ciphertext_out is updated
ciphertext_out  output  128  encrypted block; holds its value until the next completion

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset values: busy=0, valid=0, ciphertext_out=0. State register, round-key register and round counter are all 0. FSM is in IDLE.
- FSM states: IDLE, ROUND, FINAL.
- IDLE: when start=1 is sampled at edge N:
  - state <= plaintext ^ key; rk <= key; rnd <= 1; go to ROUND; busy=1 from edge N.
- ROUND (rnd = 1..9), one round per edge:
  - rk_next = KeyExpand(rk, Rcon[rnd]).
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk_next; rk <= rk_next; rnd <= rnd + 1.
  - When rnd=9 completes, go to FINAL.
- FINAL (rnd = 10):
  - ciphertext_out <= ShiftRows(SubBytes(state)) ^ KeyExpand(rk, Rcon[10]).
  - valid <= 1 for one cycle; busy <= 0; go to IDLE.
- Latency: start sampled at edge N gives valid=1 from edge N+10 for exactly one cycle.
- Throughput: one block per 11 cycles. A new start is accepted in the cycle valid is high, because the FSM is already in IDLE.
- start while busy=1: ignored and not queued. key and plaintext are not re-sampled.
- key and plaintext may change freely after the start cycle; both are captured at edge N.
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36, indexed 1..10.
- GF(2^8) arithmetic: xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0); all results are 8-bit.
- Reset mid-operation: return immediately to IDLE and clear all outputs. No valid pulse is produced for the aborted block.
- valid and busy are never high in the same cycle.

Optional Feature:
AES_SBOX_PIPE_EN
- Defined: the outputs of all 20 S-box lookups (16 data, 4 key) are registered. Each round takes 2 edges: a SUB phase, then a MIX phase.
  - FSM adds a sub-phase bit.
  - Latency: start at edge N gives valid at edge N+20.
  - busy, ignore-while-busy and reset rules are unchanged.
- Undefined: combinational S-box path, with the timing stated above.

Decomposition:
- Package aes_pkg:
  - S-box table constant
  - Rcon constant array
  - FSM state encoding constants (IDLE, ROUND, FINAL)
  - xtime function
  - byte-index helpers for column-major layout
- Sub-module aes_sbox: 8-bit in, 8-bit out, combinational lookup. Instantiated 16 times for data and 4 times for the key schedule, and reusable by other blocks.
- MixColumns and ShiftRows stay as functions in aes_pkg.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff, start at edge N -> valid at edge N+10 only, ct=69c4e0d86a7b0430d8cdb78070b4c55a; busy high during edges N..N+9.
- FIPS-197 B: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734 -> ct=3925841d02dc09fbdc118597196a0b32. Change key and pt to all-zero one cycle after start -> result unaffected.
- Back-to-back: run the C.1 vector, then assert start with the B vector in the cycle valid is high -> second valid at +11 cycles with the correct B ciphertext. A start pulse at edge N+4 of the first block is ignored: exactly 2 valid pulses total.
- Reset abort: deassert rst_n at edge N+5 of a C.1 run -> busy, valid and ciphertext_out are 0 immediately. After release, no valid appears for 20 cycles; a new C.1 run gives the correct ct.
- Known-answer: all-zero key and pt -> ct=66e94bd4ef8a2c3b884cfa59ca342b2e.
- AES_SBOX_PIPE_EN defined: repeat C.1 -> same ct, valid at edge N+20.
